// File: rtl/cpu_trace_pkg.sv
// Shared definitions for the trace character stream: ASCII constants, FSM
// state encoding, nibble-to-hex helper and the time saturation limit.
package cpu_trace_pkg;

  localparam logic [7:0] ChNul    = 8'h00;
  localparam logic [7:0] ChCaret  = 8'h5e;  // '^'
  localparam logic [7:0] ChAt     = 8'h40;  // '@'
  localparam logic [7:0] ChColon  = 8'h3a;  // ':'
  localparam logic [7:0] ChSpace  = 8'h20;  // ' '
  localparam logic [7:0] ChDollar = 8'h24;  // '$'
  localparam logic [7:0] ChStar   = 8'h2a;  // '*'
  localparam logic [7:0] ChLt     = 8'h3c;  // '<'
  localparam logic [7:0] ChEq     = 8'h3d;  // '='
  localparam logic [7:0] ChHash   = 8'h23;  // '#'

  // Largest time stamp that fits in four decimal digits.
  localparam int unsigned TimeSat = 9999;

  typedef enum logic [3:0] {
    StIdle, StCaret, StTime, StAt, StPc, StColon, StSp1, StSigil,
    StOpnd, StSp2, StLt, StEq, StSp3, StData, StHash
  } state_e;

  // Lowercase hex digit for one nibble.
  function automatic logic [7:0] hex2ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + {4'h0, nib};
    end else begin
      return 8'h57 + {4'h0, nib};
    end
  endfunction

endpackage

// File: rtl/trace_bin2bcd.sv
// Combinational double-dabble: TIME_W-bit binary to four BCD digits.
// The caller saturates the input so the value always fits in 16 BCD bits.
module trace_bin2bcd #(
  parameter int unsigned TIME_W = 14
) (
  input  logic [TIME_W-1:0] bin_i,
  output logic [15:0]       bcd_o
);

  logic [TIME_W+15:0] scratch;

  // Shift-and-add-3 over every input bit, BCD digits above the binary field.
  always_comb begin
    scratch = '0;
    scratch[TIME_W-1:0] = bin_i;
    for (int i = 0; i < int'(TIME_W); i++) begin
      for (int d = 0; d < 4; d++) begin
        if (scratch[int'(TIME_W) + 4*d +: 4] >= 4'd5) begin
          scratch[int'(TIME_W) + 4*d +: 4] = scratch[int'(TIME_W) + 4*d +: 4] + 4'd3;
        end
      end
      scratch = scratch << 1;
    end
  end

  assign bcd_o = scratch[TIME_W +: 16];

endmodule

// File: rtl/cpu_trace_serializer.sv
// Serialises one write-back record per handshake into an ASCII character
// stream, one character per clock:
//   "^<time>@<pc>: $<grf> <= <data>#"  or  "^<time>@<pc>: *<addr> <= <data>#"
// Define CPU_TRACE_ZPAD_EN to zero-pad time to 4 digits and grf to 2 digits.
module cpu_trace_serializer
  import cpu_trace_pkg::*;
#(
  parameter int unsigned TIME_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              in_kind_i,
  input  logic [TIME_W-1:0] in_time_i,
  input  logic [31:0]       in_pc_i,
  input  logic [4:0]        in_grf_i,
  input  logic [31:0]       in_addr_i,
  input  logic [31:0]       in_data_i,
  output logic [7:0]        char_out_o,
  output logic              char_valid_o,
  output logic              rec_done_o
);

`ifdef CPU_TRACE_ZPAD_EN
  localparam bit ZPad = 1'b1;
`else
  localparam bit ZPad = 1'b0;
`endif

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  char_q, char_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;

  logic        kind_q;
  logic [15:0] tbcd_q;
  logic [31:0] pc_q, addr_q, data_q;
  logic [1:0]  gtens_q;
  logic [3:0]  gunits_q;

  logic              accept;
  logic [TIME_W-1:0] time_sat;
  logic [15:0]       time_bcd;
  logic [1:0]        gtens;
  logic [3:0]        gunits;
  logic [2:0]        tstart, gstart;

  assign in_ready_o = (state_q == StIdle) || (state_q == StHash);
  assign accept     = in_valid_i && in_ready_o;

  // Clamp the time stamp before conversion so four BCD digits always suffice.
  always_comb begin
    if (32'(in_time_i) > TimeSat) begin
      time_sat = TIME_W'(TimeSat);
    end else begin
      time_sat = in_time_i;
    end
  end

  trace_bin2bcd #(
    .TIME_W (TIME_W)
  ) u_bin2bcd (
    .bin_i (time_sat),
    .bcd_o (time_bcd)
  );

  // Register number to tens/units by range compare (0..31).
  always_comb begin
    if (in_grf_i >= 5'd30) begin
      gtens  = 2'd3;
      gunits = 4'(in_grf_i - 5'd30);
    end else if (in_grf_i >= 5'd20) begin
      gtens  = 2'd2;
      gunits = 4'(in_grf_i - 5'd20);
    end else if (in_grf_i >= 5'd10) begin
      gtens  = 2'd1;
      gunits = 4'(in_grf_i - 5'd10);
    end else begin
      gtens  = 2'd0;
      gunits = in_grf_i[3:0];
    end
  end

  // First digit index to emit: skips leading zeros unless padding is enabled.
  always_comb begin
    if (ZPad || tbcd_q[15:12] != 4'd0) begin
      tstart = 3'd3;
    end else if (tbcd_q[11:8] != 4'd0) begin
      tstart = 3'd2;
    end else if (tbcd_q[7:4] != 4'd0) begin
      tstart = 3'd1;
    end else begin
      tstart = 3'd0;
    end
    gstart = (ZPad || gtens_q != 2'd0) ? 3'd1 : 3'd0;
  end

  // Next state and digit counter; multi-digit fields count down to zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StCaret;
      StCaret: begin
        state_d = StTime;
        cnt_d   = tstart;
      end
      StTime:  if (cnt_q == 3'd0) state_d = StAt; else cnt_d = cnt_q - 3'd1;
      StAt: begin
        state_d = StPc;
        cnt_d   = 3'd7;
      end
      StPc:    if (cnt_q == 3'd0) state_d = StColon; else cnt_d = cnt_q - 3'd1;
      StColon: state_d = StSp1;
      StSp1:   state_d = StSigil;
      StSigil: begin
        state_d = StOpnd;
        cnt_d   = kind_q ? 3'd7 : gstart;
      end
      StOpnd:  if (cnt_q == 3'd0) state_d = StSp2; else cnt_d = cnt_q - 3'd1;
      StSp2:   state_d = StLt;
      StLt:    state_d = StEq;
      StEq:    state_d = StSp3;
      StSp3: begin
        state_d = StData;
        cnt_d   = 3'd7;
      end
      StData:  if (cnt_q == 3'd0) state_d = StHash; else cnt_d = cnt_q - 3'd1;
      StHash:  state_d = accept ? StCaret : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Character for the state being entered, so char_out lines up with state_q.
  always_comb begin
    char_d  = ChNul;
    valid_d = 1'b1;
    unique case (state_d)
      StIdle:  valid_d = 1'b0;
      StCaret: char_d = ChCaret;
      StTime:  char_d = hex2ascii(tbcd_q[{cnt_d[1:0], 2'b00} +: 4]);
      StAt:    char_d = ChAt;
      StPc:    char_d = hex2ascii(pc_q[{cnt_d, 2'b00} +: 4]);
      StColon: char_d = ChColon;
      StSp1:   char_d = ChSpace;
      StSigil: char_d = kind_q ? ChStar : ChDollar;
      StOpnd: begin
        if (kind_q) begin
          char_d = hex2ascii(addr_q[{cnt_d, 2'b00} +: 4]);
        end else if (cnt_d[0]) begin
          char_d = hex2ascii({2'b00, gtens_q});
        end else begin
          char_d = hex2ascii(gunits_q);
        end
      end
      StSp2:   char_d = ChSpace;
      StLt:    char_d = ChLt;
      StEq:    char_d = ChEq;
      StSp3:   char_d = ChSpace;
      StData:  char_d = hex2ascii(data_q[{cnt_d, 2'b00} +: 4]);
      StHash:  char_d = ChHash;
      default: valid_d = 1'b0;
    endcase
    done_d = (state_d == StHash);
  end

  // State, registered outputs and captured record fields.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= 3'd0;
      char_q   <= ChNul;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      kind_q   <= 1'b0;
      tbcd_q   <= 16'd0;
      pc_q     <= 32'd0;
      addr_q   <= 32'd0;
      data_q   <= 32'd0;
      gtens_q  <= 2'd0;
      gunits_q <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      char_q  <= char_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      if (accept) begin
        kind_q   <= in_kind_i;
        tbcd_q   <= time_bcd;
        pc_q     <= in_pc_i;
        addr_q   <= in_addr_i;
        data_q   <= in_data_i;
        gtens_q  <= gtens;
        gunits_q <= gunits;
      end
    end
  end

  assign char_out_o   = char_q;
  assign char_valid_o = valid_q;
  assign rec_done_o   = done_q;

endmodule
